// File: rtl/gate_logic_array_pkg.sv
// gate_logic_pkg: shared constants and helpers for the gate logic array.
//   EDGE_TOGGLE / EDGE_RISE / EDGE_FALL : legal values of EDGE_MODE
//   cnt_width()                         : width of a per-channel fire counter
//   popcount()                          : number of set bits in a 64-bit vector
package gate_logic_pkg;

    localparam int EDGE_TOGGLE = 0;
    localparam int EDGE_RISE   = 1;
    localparam int EDGE_FALL   = 2;

    // The counter must be able to hold MAX_FIRES itself.
    function automatic int cnt_width(input int max_fires);
        return $clog2(max_fires + 1);
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gate_logic_array_if.sv
// gate_logic_array_if: per-cycle bundle between the wire-state network, the
// gate array and the logic scheduler.
//   epoch_clear : start a new logic epoch (synchronous, active-high)
//   chan_en     : per-channel enable
//   in          : wire state per channel
//   out         : fire pulse per channel
//   exhausted   : channel has spent its fire budget this epoch
//   fire_any    : OR of the fire bits on out's timing
//   fire_total  : popcount of the fire bits on out's timing
//
// There is no valid/ready handshake: every clock cycle is one transaction,
// the inputs are sampled on every posedge and the outputs are always valid.
interface gate_logic_array_if #(
    parameter int CHANNELS = 8
);
    localparam int FTW = $clog2(CHANNELS + 1);

    logic                epoch_clear;
    logic [CHANNELS-1:0] chan_en;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] exhausted;
    logic                fire_any;
    logic [FTW-1:0]      fire_total;

    modport master (
        output epoch_clear, chan_en, in,
        input  out, exhausted, fire_any, fire_total
    );

    modport slave (
        input  epoch_clear, chan_en, in,
        output out, exhausted, fire_any, fire_total
    );
endinterface

// File: rtl/gate_logic_array_channel.sv
// gate_logic_channel: one edge-qualified, budget-limited fire channel.
//   clk, rst_n   : clock, asynchronous active-low reset
//   epoch_clear  : resets the fire counter (wins over an increment)
//   chan_en      : channel enable; edges seen while low are consumed
//   wire_in      : watched wire level
//   fire         : same-cycle fire pulse
//   exhausted    : fire counter has reached MAX_FIRES
//   fire_cnt     : fire counter (debug visibility)
module gate_logic_channel
    import gate_logic_pkg::*;
#(
    parameter int MAX_FIRES = 1,
    parameter int EDGE_MODE = EDGE_TOGGLE,
    localparam int CW       = cnt_width(MAX_FIRES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          epoch_clear,
    input  logic          chan_en,
    input  logic          wire_in,
    output logic          fire,
    output logic          exhausted,
    output logic [CW-1:0] fire_cnt
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FIRES);

    if (MAX_FIRES < 1) begin : g_bad_fires
        $error("gate_logic_channel: MAX_FIRES must be at least 1");
    end
    if (EDGE_MODE != EDGE_TOGGLE && EDGE_MODE != EDGE_RISE && EDGE_MODE != EDGE_FALL) begin : g_bad_mode
        $error("gate_logic_channel: EDGE_MODE must be 0, 1 or 2");
    end

    logic          prev_in_q, prev_in_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] fire_cnt_q, fire_cnt_d;
    logic          edge_raw;

    always_comb begin
        edge_raw = 1'b0;
        case (EDGE_MODE)
            EDGE_RISE: edge_raw = ~prev_in_q & wire_in;
            EDGE_FALL: edge_raw = prev_in_q & ~wire_in;
            default:   edge_raw = prev_in_q ^ wire_in;
        endcase

        exhausted = (fire_cnt_q == MAX_CNT);
        // armed_q keeps the reset-release cycle silent: prev_in is only
        // meaningful once it has captured a real wire level.
        fire = armed_q & chan_en & edge_raw & ~exhausted;

        // prev_in always tracks the wire, so edges seen while disabled or
        // exhausted are consumed rather than replayed later.
        prev_in_d = wire_in;
        armed_d   = 1'b1;

        fire_cnt_d = fire_cnt_q;
        if (epoch_clear) begin
            fire_cnt_d = '0;
        end else if (fire) begin
            fire_cnt_d = fire_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_in_q  <= 1'b0;
            armed_q    <= 1'b0;
            fire_cnt_q <= '0;
        end else begin
            prev_in_q  <= prev_in_d;
            armed_q    <= armed_d;
            fire_cnt_q <= fire_cnt_d;
        end
    end

    assign fire_cnt = fire_cnt_q;

endmodule

// File: rtl/gate_logic_array.sv
// gate_logic_array: CHANNELS independent one-shot/multi-shot gate channels
// with optional output register and per-cycle fire activity summary.
//   clk           : clock, all state updates on posedge
//   logic_reset_n : asynchronous active-low reset
//   bus           : gate_logic_array_if slave (epoch_clear, chan_en, in ->
//                   out, exhausted, fire_any, fire_total)
// Parameters: CHANNELS (1..64), MAX_FIRES (>=1), EDGE_MODE (0 toggle,
// 1 rise, 2 fall), REG_OUT (0 combinational out, 1 registered out).
module gate_logic_array
    import gate_logic_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int MAX_FIRES = 1,
    parameter int EDGE_MODE = EDGE_TOGGLE,
    parameter int REG_OUT   = 0
) (
    input logic               clk,
    input logic               logic_reset_n,
    gate_logic_array_if.slave bus
);

    localparam int FTW = $clog2(CHANNELS + 1);
    localparam int CW  = cnt_width(MAX_FIRES);

    if (CHANNELS < 1 || CHANNELS > 64) begin : g_bad_channels
        $error("gate_logic_array: CHANNELS must be in 1..64");
    end

    logic [CHANNELS-1:0] fire_vec;
    logic [CHANNELS-1:0] exhausted_vec;
    logic [CHANNELS-1:0] fire_out;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CW-1:0] fire_cnt;

        gate_logic_channel #(
            .MAX_FIRES (MAX_FIRES),
            .EDGE_MODE (EDGE_MODE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (logic_reset_n),
            .epoch_clear (bus.epoch_clear),
            .chan_en     (bus.chan_en[g]),
            .wire_in     (bus.in[g]),
            .fire        (fire_vec[g]),
            .exhausted   (exhausted_vec[g]),
            .fire_cnt    (fire_cnt)
        );
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [CHANNELS-1:0] out_q, out_d;

        always_comb begin
            out_d = fire_vec;
        end

        always_ff @(posedge clk or negedge logic_reset_n) begin
            if (!logic_reset_n) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign fire_out = out_q;
    end else begin : g_comb_out
        // fire already includes armed, so out is 0 until the channel arms.
        assign fire_out = fire_vec;
    end

    assign bus.out        = fire_out;
    assign bus.exhausted  = exhausted_vec;
    assign bus.fire_any   = |fire_out;
    assign bus.fire_total = FTW'(popcount(64'(fire_out)));

endmodule

// File: tb/tb_gate_logic_array.sv
// tb_gate_logic_array: self-checking bench for gate_logic_array. Four
// instances cover the configurations of interest:
//   dut_a : 1 channel, MAX_FIRES=1, toggle, combinational out
//   dut_b : 2 channels, MAX_FIRES=3, rising, combinational out
//   dut_c : 1 channel, MAX_FIRES=2, rising, combinational out
//   dut_d : 8 channels, MAX_FIRES=1, toggle, registered out
// Observed outputs are packed as {out, exhausted, 3'b0, fire_any, fire_total}.
module tb_gate_logic_array;

    logic clk;
    logic rst_a, rst_b, rst_c, rst_d;

    gate_logic_array_if #(.CHANNELS(1)) if_a ();
    gate_logic_array_if #(.CHANNELS(2)) if_b ();
    gate_logic_array_if #(.CHANNELS(1)) if_c ();
    gate_logic_array_if #(.CHANNELS(8)) if_d ();

    gate_logic_array #(.CHANNELS(1), .MAX_FIRES(1), .EDGE_MODE(0), .REG_OUT(0))
        dut_a (.clk(clk), .logic_reset_n(rst_a), .bus(if_a.slave));
    gate_logic_array #(.CHANNELS(2), .MAX_FIRES(3), .EDGE_MODE(1), .REG_OUT(0))
        dut_b (.clk(clk), .logic_reset_n(rst_b), .bus(if_b.slave));
    gate_logic_array #(.CHANNELS(1), .MAX_FIRES(2), .EDGE_MODE(1), .REG_OUT(0))
        dut_c (.clk(clk), .logic_reset_n(rst_c), .bus(if_c.slave));
    gate_logic_array #(.CHANNELS(8), .MAX_FIRES(1), .EDGE_MODE(0), .REG_OUT(1))
        dut_d (.clk(clk), .logic_reset_n(rst_d), .bus(if_d.slave));

    logic [23:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic logic [23:0] pack(input logic [7:0] o, input logic [7:0] e,
                                         input logic a, input logic [3:0] t);
        return {o, e, 3'b000, a, t};
    endfunction

    function automatic logic [23:0] pack_exp(input logic [7:0] o, input logic [7:0] e);
        return pack(o, e, |o, 4'($countones(o)));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [23:0] obs, exp_w;
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pack_exp(8'h00, 8'h00));
            case (k)
                0: obs = pack(8'(if_a.out), 8'(if_a.exhausted), if_a.fire_any, 4'(if_a.fire_total));
                1: obs = pack(8'(if_b.out), 8'(if_b.exhausted), if_b.fire_any, 4'(if_b.fire_total));
                2: obs = pack(8'(if_c.out), 8'(if_c.exhausted), if_c.fire_any, 4'(if_c.fire_total));
                default: obs = pack(if_d.out, if_d.exhausted, if_d.fire_any, if_d.fire_total);
            endcase
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL reset dut%0d: got %h want %h", k, obs, exp_w);
                n_mis++;
            end
        end
    endtask

    task automatic test_one_shot();
        bit t_in [6]  = '{0, 1, 0, 0, 1, 1};
        bit t_clr[6]  = '{0, 0, 0, 1, 0, 0};
        bit t_out[6]  = '{0, 1, 0, 0, 1, 0};
        bit t_ex [6]  = '{0, 0, 1, 1, 0, 1};
        logic [23:0] obs, exp_w;
        @(negedge clk);
        rst_a = 1'b1;   // step 0 below is the arming cycle
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if_a.in          = t_in[i];
            if_a.epoch_clear = t_clr[i];
            exp_q.push_back(pack_exp(8'(t_out[i]), 8'(t_ex[i])));
            #1;
            obs   = pack(8'(if_a.out), 8'(if_a.exhausted), if_a.fire_any, 4'(if_a.fire_total));
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL one_shot step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
        end
        if_a.epoch_clear = 1'b0;
    endtask

    task automatic test_arming();
        bit t_in [5] = '{1, 1, 1, 0, 0};
        bit t_out[5] = '{0, 0, 0, 1, 0};
        bit t_ex [5] = '{0, 0, 0, 0, 1};
        logic [23:0] obs, exp_w;
        @(negedge clk);
        rst_a   = 1'b0;
        if_a.in = 1'b1;
        exp_q.push_back(pack_exp(8'h00, 8'h00));
        #1;
        obs   = pack(8'(if_a.out), 8'(if_a.exhausted), if_a.fire_any, 4'(if_a.fire_total));
        exp_w = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_w) begin
            $display("FAIL arming in_reset: got %h want %h", obs, exp_w);
            n_mis++;
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if_a.in = t_in[i];
            exp_q.push_back(pack_exp(8'(t_out[i]), 8'(t_ex[i])));
            #1;
            obs   = pack(8'(if_a.out), 8'(if_a.exhausted), if_a.fire_any, 4'(if_a.fire_total));
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL arming step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
        end
    endtask

    task automatic test_budget();
        bit t_in [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        bit t_out[9] = '{0, 1, 0, 1, 0, 1, 0, 0, 0};
        bit t_ex [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic [23:0] obs, exp_w;
        @(negedge clk);
        rst_b = 1'b1;
        if_b.chan_en = 2'b11;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if_b.in = {1'b0, t_in[i]};
            exp_q.push_back(pack_exp(8'(t_out[i]), 8'(t_ex[i])));
            #1;
            obs   = pack(8'(if_b.out), 8'(if_b.exhausted), if_b.fire_any, 4'(if_b.fire_total));
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL budget step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
        end
    endtask

    task automatic test_clear_collision();
        bit t_in [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        bit t_clr[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
        bit t_out[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        bit t_ex [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [23:0] obs, exp_w;
        @(negedge clk);
        rst_c = 1'b1;
        if_c.chan_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if_c.in          = t_in[i];
            if_c.epoch_clear = t_clr[i];
            exp_q.push_back(pack_exp(8'(t_out[i]), 8'(t_ex[i])));
            #1;
            obs   = pack(8'(if_c.out), 8'(if_c.exhausted), if_c.fire_any, 4'(if_c.fire_total));
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL clear_collision step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
        end
        if_c.epoch_clear = 1'b0;
    endtask

    // Registered output: the expectation pushed with a step is popped at the
    // next negedge, after the posedge that registers it.
    task automatic test_multi_channel();
        bit         t_clr[6] = '{0, 0, 1, 0, 0, 0};
        logic [7:0] t_en [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
        logic [7:0] t_in [6] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'hE5};
        logic [7:0] t_out[6] = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h40};
        logic [7:0] t_ex [6] = '{8'hA5, 8'hA5, 8'h00, 8'h05, 8'h05, 8'h45};
        logic [23:0] obs, exp_w;
        @(negedge clk);
        rst_d = 1'b1;
        if_d.chan_en     = 8'hFF;
        if_d.in          = 8'h00;
        if_d.epoch_clear = 1'b0;
        exp_q.push_back(pack_exp(8'h00, 8'h00));
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            #1;
            obs   = pack(if_d.out, if_d.exhausted, if_d.fire_any, if_d.fire_total);
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL multi_channel step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
            if (i < 6) begin
                if_d.epoch_clear = t_clr[i];
                if_d.chan_en     = t_en[i];
                if_d.in          = t_in[i];
                exp_q.push_back(pack_exp(t_out[i], t_ex[i]));
            end
        end
    endtask

    task automatic test_async_reset_mid_epoch();
        logic [7:0] t_in [2] = '{8'hE4, 8'hE4};
        logic [7:0] t_out[2] = '{8'h01, 8'h00};
        logic [7:0] t_ex [2] = '{8'h01, 8'h01};
        logic [23:0] obs, exp_w;
        // out is registered high (0x40) here; drop reset between edges.
        #2;
        rst_d = 1'b0;
        exp_q.push_back(pack_exp(8'h00, 8'h00));
        #1;
        obs   = pack(if_d.out, if_d.exhausted, if_d.fire_any, if_d.fire_total);
        exp_w = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_w) begin
            $display("FAIL async_reset immediate: got %h want %h", obs, exp_w);
            n_mis++;
        end
        @(negedge clk);
        rst_d = 1'b1;   // in stays 0xE5: a held level is not an edge
        exp_q.push_back(pack_exp(8'h00, 8'h00));
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            #1;
            obs   = pack(if_d.out, if_d.exhausted, if_d.fire_any, if_d.fire_total);
            exp_w = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_w) begin
                $display("FAIL async_reset step %0d: got %h want %h", i, obs, exp_w);
                n_mis++;
            end
            if (i < 2) begin
                if_d.in = t_in[i];
                exp_q.push_back(pack_exp(t_out[i], t_ex[i]));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        if_a.epoch_clear = 1'b0; if_a.chan_en = 1'b1;  if_a.in = 1'b0;
        if_b.epoch_clear = 1'b0; if_b.chan_en = 2'b11; if_b.in = 2'b00;
        if_c.epoch_clear = 1'b0; if_c.chan_en = 1'b1;  if_c.in = 1'b0;
        if_d.epoch_clear = 1'b0; if_d.chan_en = 8'hFF; if_d.in = 8'h00;

        test_reset();
        test_one_shot();
        test_arming();
        test_budget();
        test_clear_collision();
        test_multi_channel();
        test_async_reset_mid_epoch();

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
